// File: rtl/servo_setpoint_ramper_if.sv
// Command and setpoint-output bundle for servo_setpoint_ramper.
// The source drives the cmd_* handshake, and the ramper drives the per-servo output strobe.
interface servo_setpoint_ramper_if #(
    parameter int unsigned NUM_SERVOS = 4,
    parameter int unsigned DUTY_W     = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_addr;
    logic [DUTY_W-1:0]     cmd_duty;
    logic [1:0]            servo_address;
    logic [DUTY_W-1:0]     switch_duty_cycle;
    logic                  out_valid;
    logic [NUM_SERVOS-1:0] at_target;

    modport master (
        output cmd_valid, cmd_addr, cmd_duty,
        input  cmd_ready, servo_address, switch_duty_cycle, out_valid, at_target
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_duty,
        output cmd_ready, servo_address, switch_duty_cycle, out_valid, at_target
    );
endinterface

// File: rtl/servo_setpoint_ramper.sv
// Slews each servo's live setpoint toward its commanded target by at most STEP per update tick.
// On every tick it emits one (servo_address, switch_duty_cycle) strobe per servo, in ascending order.
module servo_setpoint_ramper #(
    parameter int unsigned NUM_SERVOS = 4,
    parameter int unsigned DUTY_W     = 8,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned STEP       = 1,
    parameter int unsigned RESET_DUTY = 0
) (
    input logic                    clock,
    input logic                    reset,
    servo_setpoint_ramper_if.slave bus
);
    localparam int unsigned       CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [1:0]        IDX_LAST = 2'(NUM_SERVOS - 1);
    localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(RESET_DUTY);
    localparam logic [DUTY_W:0]   STEP_W   = (DUTY_W + 1)'(STEP);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  tick;
    logic [1:0]            idx_q, idx_d;
    logic [DUTY_W-1:0]     cur_q [NUM_SERVOS];
    logic [DUTY_W-1:0]     cur_d [NUM_SERVOS];
    logic [DUTY_W-1:0]     tgt_q [NUM_SERVOS];
    logic [DUTY_W-1:0]     tgt_d [NUM_SERVOS];
    logic [1:0]            addr_q, addr_d;
    logic [DUTY_W-1:0]     duty_q, duty_d;
    logic                  valid_q, valid_d;
    logic [NUM_SERVOS-1:0] at_q, at_d;
    logic                  accept;
    logic [DUTY_W-1:0]     slewed;

    // The gap is compared in DUTY_W+1 bits, so the step can never wrap or overshoot the target.
    function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] cur,
                                               input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] gap;
        gap = '0;
        if (cur < tgt) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            return (gap <= STEP_W) ? tgt : cur + DUTY_W'(STEP);
        end else if (cur > tgt) begin
            gap = {1'b0, cur} - {1'b0, tgt};
            return (gap <= STEP_W) ? tgt : cur - DUTY_W'(STEP);
        end
        return cur;
    endfunction

    assign tick   = (cnt_q == CNT_LAST);
    assign accept = bus.cmd_valid && (state_q == StIdle);
    assign slewed = slew(cur_q[idx_q], tgt_q[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        addr_d  = addr_q;
        duty_d  = duty_q;
        valid_d = 1'b0;
        at_d    = '0;

        // Out-of-range addresses are acknowledged but dropped.
        if (accept && (32'(bus.cmd_addr) < NUM_SERVOS)) begin
            tgt_d[bus.cmd_addr] = bus.cmd_duty;
        end

        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StEmit;
                    idx_d   = '0;
                end
            end
            StEmit: begin
                cur_d[idx_q] = slewed;
                addr_d       = idx_q;
                duty_d       = slewed;
                valid_d      = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        for (int i = 0; i < NUM_SERVOS; i++) begin
            at_d[i] = (cur_d[i] == tgt_d[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            idx_q   <= '0;
            for (int i = 0; i < NUM_SERVOS; i++) begin
                cur_q[i] <= DUTY_RST;
                tgt_q[i] <= DUTY_RST;
            end
            addr_q  <= '0;
            duty_q  <= DUTY_RST;
            valid_q <= 1'b0;
            at_q    <= '1;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
            state_q <= state_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            addr_q  <= addr_d;
            duty_q  <= duty_d;
            valid_q <= valid_d;
            at_q    <= at_d;
        end
    end

    assign bus.cmd_ready         = (state_q == StIdle);
    assign bus.servo_address     = addr_q;
    assign bus.switch_duty_cycle = duty_q;
    assign bus.out_valid         = valid_q;
    assign bus.at_target         = at_q;
endmodule

// File: tb/tb_servo_setpoint_ramper.sv
// Directed bench: three rampers (STEP 1, 4, 200) share clock and reset, with TICK_DIV=8.
// Expected setpoint sequences are hand-computed.
module tb_servo_setpoint_ramper;
    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_start = 0;
    bit   have_last = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    servo_setpoint_ramper_if #(.NUM_SERVOS(4), .DUTY_W(8)) if_a ();
    servo_setpoint_ramper_if #(.NUM_SERVOS(4), .DUTY_W(8)) if_b ();
    servo_setpoint_ramper_if #(.NUM_SERVOS(4), .DUTY_W(8)) if_c ();

    servo_setpoint_ramper #(.NUM_SERVOS(4), .DUTY_W(8), .TICK_DIV(8), .STEP(1), .RESET_DUTY(0))
        u_a (.clock(clock), .reset(reset), .bus(if_a));
    servo_setpoint_ramper #(.NUM_SERVOS(4), .DUTY_W(8), .TICK_DIV(8), .STEP(4), .RESET_DUTY(0))
        u_b (.clock(clock), .reset(reset), .bus(if_b));
    servo_setpoint_ramper #(.NUM_SERVOS(4), .DUTY_W(8), .TICK_DIV(8), .STEP(200), .RESET_DUTY(0))
        u_c (.clock(clock), .reset(reset), .bus(if_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        if_a.cmd_valid = 1'b0; if_a.cmd_addr = '0; if_a.cmd_duty = '0;
        if_b.cmd_valid = 1'b0; if_b.cmd_addr = '0; if_b.cmd_duty = '0;
        if_c.cmd_valid = 1'b0; if_c.cmd_addr = '0; if_c.cmd_duty = '0;
    endtask

    // Expected words are packed {servo3, servo2, servo1, servo0}, one byte each.
    task automatic capture_sweep(input string tag, input logic [31:0] ea,
                                 input logic [31:0] eb, input logic [31:0] ec);
        int n = 0;
        while (!if_a.out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("%s first strobe", tag), if_a.out_valid, 1);
        if (have_last) check($sformatf("%s spacing", tag), cyc - last_start, 8);
        last_start = cyc;
        have_last  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s valid s%0d", tag, k), if_a.out_valid, 1);
            check($sformatf("%s addr s%0d", tag, k), if_a.servo_address, k);
            check($sformatf("%s dutyA s%0d", tag, k), if_a.switch_duty_cycle, ea[8*k +: 8]);
            check($sformatf("%s dutyB s%0d", tag, k), if_b.switch_duty_cycle, eb[8*k +: 8]);
            check($sformatf("%s dutyC s%0d", tag, k), if_c.switch_duty_cycle, ec[8*k +: 8]);
            @(negedge clock);
        end
        check($sformatf("%s gap", tag), if_a.out_valid, 0);
    endtask

    initial begin
        int n;
        idle_all();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst valid", if_a.out_valid, 0);
        check("rst duty", if_a.switch_duty_cycle, 0);
        check("rst addr", if_a.servo_address, 0);
        check("rst ready", if_a.cmd_ready, 1);
        check("rst at_target", if_a.at_target, 4'hF);
        reset = 1'b1;

        // Ramp up (A), ramp down (B) and saturation (C) commands issued together.
        @(negedge clock);
        if_a.cmd_valid = 1'b1; if_a.cmd_addr = 2'd2; if_a.cmd_duty = 8'd3;
        if_b.cmd_valid = 1'b1; if_b.cmd_addr = 2'd0; if_b.cmd_duty = 8'd10;
        if_c.cmd_valid = 1'b1; if_c.cmd_addr = 2'd1; if_c.cmd_duty = 8'd255;
        @(negedge clock);
        idle_all();
        check("A at_target after accept", if_a.at_target, 4'b1011);
        check("B at_target after accept", if_b.at_target, 4'b1110);
        check("C at_target after accept", if_c.at_target, 4'b1101);

        capture_sweep("sw1", 32'h0001_0000, 32'h0000_0004, 32'h0000_C800);
        capture_sweep("sw2", 32'h0002_0000, 32'h0000_0008, 32'h0000_FF00);
        check("A at_target sw2", if_a.at_target, 4'hB);
        check("C at_target sw2", if_c.at_target, 4'hF);
        if_c.cmd_valid = 1'b1; if_c.cmd_addr = 2'd1; if_c.cmd_duty = 8'd0;
        @(negedge clock);
        idle_all();

        capture_sweep("sw3", 32'h0003_0000, 32'h0000_000A, 32'h0000_3700);
        check("A at_target sw3", if_a.at_target, 4'hF);
        check("B at_target sw3", if_b.at_target, 4'hF);
        check("C at_target sw3", if_c.at_target, 4'hD);
        if_b.cmd_valid = 1'b1; if_b.cmd_addr = 2'd0; if_b.cmd_duty = 8'd1;
        @(negedge clock);
        idle_all();
        check("B at_target down", if_b.at_target, 4'hE);

        capture_sweep("sw4", 32'h0003_0000, 32'h0000_0006, 32'h0000_0000);
        capture_sweep("sw5", 32'h0003_0000, 32'h0000_0002, 32'h0000_0000);
        capture_sweep("sw6", 32'h0003_0000, 32'h0000_0001, 32'h0000_0000);
        capture_sweep("sw7", 32'h0003_0000, 32'h0000_0001, 32'h0000_0000);
        check("B at_target settled", if_b.at_target, 4'hF);

        // Collision: command in the tick cycle, then a second one held through EMIT.
        repeat (2) @(negedge clock);
        check("col ready tick", if_a.cmd_ready, 1);
        if_a.cmd_valid = 1'b1; if_a.cmd_addr = 2'd1; if_a.cmd_duty = 8'd5;
        @(negedge clock);
        check("col ready emit0", if_a.cmd_ready, 0);
        if_a.cmd_duty = 8'd7;
        @(negedge clock);
        last_start = cyc;
        check("col ready emit1", if_a.cmd_ready, 0);
        check("col s0 addr", if_a.servo_address, 0);
        check("col s0 duty", if_a.switch_duty_cycle, 0);
        @(negedge clock);
        check("col ready emit2", if_a.cmd_ready, 0);
        check("col s1 duty", if_a.switch_duty_cycle, 1);
        @(negedge clock);
        check("col ready emit3", if_a.cmd_ready, 0);
        check("col s2 duty", if_a.switch_duty_cycle, 3);
        @(negedge clock);
        check("col ready idle", if_a.cmd_ready, 1);
        check("col s3 addr", if_a.servo_address, 3);
        check("col s3 valid", if_a.out_valid, 1);
        @(negedge clock);
        check("col done", if_a.out_valid, 0);
        if_a.cmd_addr = 2'd3; if_a.cmd_duty = 8'd9;
        @(negedge clock);
        if_a.cmd_duty = 8'd2;
        @(negedge clock);
        idle_all();
        check("A at_target lastwins", if_a.at_target, 4'b0101);
        capture_sweep("sw8", 32'h0103_0200, 32'h0000_0001, 32'h0000_0000);

        // Reset in the middle of a sweep.
        n = 0;
        while (!if_a.out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("midsweep strobe", if_a.out_valid, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst valid", if_a.out_valid, 0);
        check("midrst duty", if_a.switch_duty_cycle, 0);
        check("midrst addr", if_a.servo_address, 0);
        check("midrst ready", if_a.cmd_ready, 1);
        check("midrst at_target A", if_a.at_target, 4'hF);
        check("midrst at_target B", if_b.at_target, 4'hF);
        @(negedge clock);
        reset = 1'b1;
        have_last = 1'b0;
        capture_sweep("post-rst", 32'h0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
